// File: rtl/chunked_addsub_unit.sv
// Multi-cycle add/subtract unit: the carry chain is cut into CHUNK-bit slices,
// one slice per clock, with Y86-style ZF/SF/OF flags and a valid/ready handshake.
module chunked_addsub_unit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             cout,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    localparam int NCH   = WIDTH / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCH - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("chunked_addsub_unit: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d, zf_q, zf_d, sf_q, sf_d, of_q, of_d;
    logic             init_q;

    int               base;
    logic [CHUNK-1:0] a_sl, b_sl;
    logic [CHUNK:0]   sum;

    always_comb begin
        base = CHUNK * int'(idx_q);
        a_sl = a_q[base +: CHUNK];
        b_sl = b_q[base +: CHUNK];
        sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    end

    assign in_ready  = init_q && rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign Y         = y_q;
    assign cout      = cout_q;
    assign zf        = zf_q;
    assign sf        = sf_q;
    assign of        = of_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        zf_d    = zf_q;
        sf_d    = sf_q;
        of_d    = of_q;
        case (state_q)
            S_IDLE: begin
                // Subtraction is A + ~B + 1: invert B once here, seed the carry.
                if (in_valid && in_ready) begin
                    a_d     = A;
                    b_d     = op_sub ? ~B : B;
                    carry_d = op_sub;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                y_d[base +: CHUNK] = sum[CHUNK-1:0];
                carry_d = sum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                    cout_d  = sum[CHUNK];
                    sf_d    = y_d[WIDTH-1];
                    zf_d    = (y_d == '0);
                    of_d    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (y_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            y_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            zf_q    <= 1'b0;
            sf_q    <= 1'b0;
            of_q    <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            zf_q    <= zf_d;
            sf_q    <= sf_d;
            of_q    <= of_d;
            init_q  <= 1'b1;
        end
    end

    // Operand latches only matter once an op is accepted, so they carry no reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

endmodule
